// File: rtl/ram_dp_pkg.sv
// Shared sizing for the dual-port RAM FIFO controller: default widths,
// depth helper and pointer width.
package ram_dp_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

    function automatic int unsigned depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // One extra MSB so that full and empty differ when the low bits match.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ram_dp_fifo_outreg.sv
// Prefetch output register: pulls one committed word from the RAM read port
// and holds it as a valid/ready stream.
module ram_dp_fifo_outreg
    import ram_dp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  avail,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  load,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    // A flush moves the read pointer instead, so no word may be taken that cycle.
    assign load = avail & (~out_valid | out_ready) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_dp_fifo_ctrl.sv
// FIFO controller in front of a dual-port asynchronous RAM: port 0 writes,
// port 1 reads, pointers/occupancy live here and the RAM holds storage only.
module ram_dp_fifo_ctrl
    import ram_dp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [ADDR_WIDTH-1:0] ram_addr_1,
    output logic                  ram_cs_1,
    output logic                  ram_we_1,
    output logic                  ram_oe_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1
);

    localparam int unsigned      PTR_W   = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(depth(ADDR_WIDTH));
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic [PTR_W-1:0]      occ;
    logic [PTR_W-1:0]      committed;
    logic                  push;
    logic                  load;
    logic                  avail;

    assign occ       = wr_ptr - rd_ptr;
    // The word still sitting in the write stage is counted but not yet readable.
    assign committed = occ - PTR_W'(wr_pend);
    assign avail     = (committed != '0);

    assign in_ready = (occ != DEPTH_P) & rst_n;
    assign push     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_pend   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                wr_addr_q <= wr_ptr[ADDR_WIDTH-1:0];
                wr_data_q <= in_data;
            end
            wr_pend <= push;
        end
    end

    ram_dp_fifo_outreg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .avail    (avail),
        .out_ready(out_ready),
        .rd_data  (ram_data_1),
        .load     (load),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    assign level = {1'b0, occ} + (ADDR_WIDTH + 2)'(out_valid);

    assign ram_addr_0 = wr_addr_q;
    assign ram_data_0 = wr_data_q;
    assign ram_cs_0   = wr_pend;
    assign ram_we_0   = wr_pend;
    assign ram_oe_0   = 1'b0;

    // Chip select drops while empty so the RAM re-evaluates on the next commit.
    assign ram_addr_1 = rd_ptr[ADDR_WIDTH-1:0];
    assign ram_cs_1   = avail;
    assign ram_we_1   = 1'b0;
    assign ram_oe_1   = 1'b1;

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Directed bench for ram_dp_fifo_ctrl with a behavioural RAM and a word scoreboard.
module tb_ram_dp_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [9:0] level;
    logic [7:0] ram_addr_0;
    logic [7:0] ram_data_0;
    logic       ram_cs_0;
    logic       ram_we_0;
    logic       ram_oe_0;
    logic [7:0] ram_addr_1;
    logic       ram_cs_1;
    logic       ram_we_1;
    logic       ram_oe_1;
    logic [7:0] ram_data_1;

    logic [7:0] mem [256];
    logic [7:0] sb [$];
    int tests = 0;
    int fails = 0;
    int pushes = 0;
    int pops = 0;
    logic [7:0] last_pop;

    always #5 clk = ~clk;

    ram_dp_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .ram_addr_0(ram_addr_0),
        .ram_data_0(ram_data_0),
        .ram_cs_0  (ram_cs_0),
        .ram_we_0  (ram_we_0),
        .ram_oe_0  (ram_oe_0),
        .ram_addr_1(ram_addr_1),
        .ram_cs_1  (ram_cs_1),
        .ram_we_1  (ram_we_1),
        .ram_oe_1  (ram_oe_1),
        .ram_data_1(ram_data_1)
    );

    always @(posedge clk) begin
        if (ram_cs_0 && ram_we_0) mem[ram_addr_0] <= ram_data_0;
    end
    assign ram_data_1 = ram_cs_1 ? mem[ram_addr_1] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard update at the negedge before each active edge, then step past the edge.
    task automatic tick();
        logic [7:0] exp;
        @(negedge clk);
        check("level_vs_model", 32'(level), 32'(sb.size()));
        if (ram_cs_0 && ram_cs_1)
            check("rd_wr_same_slot", 32'(ram_addr_0 == ram_addr_1), 32'd0);
        if (out_valid && out_ready) begin
            pops++;
            last_pop = out_data;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL pop_underflow: observed pop of 0x%0h expected no output", out_data);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("pop_data", 32'(out_data), 32'(exp));
            end
        end
        if (flush) sb.delete();
        if (in_valid && in_ready) begin
            sb.push_back(in_data);
            pushes++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 600 && sb.size() != 0; i++) tick();
        check(tag, 32'(sb.size()), 32'd0);
        tick();
        check({tag, "_level"}, 32'(level), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int p0;
        int q0;
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cs0_we0", 32'({ram_cs_0, ram_we_0}), 32'd0);
        check("rst_cs1", 32'(ram_cs_1), 32'd0);
        check("const_oe_we", 32'({ram_oe_0, ram_we_1, ram_oe_1}), 32'b001);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single word latency
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        check("t1_we0", 32'({ram_cs_0, ram_we_0}), 32'b11);
        check("t1_addr0", 32'(ram_addr_0), 32'h00);
        check("t1_data0", 32'(ram_data_0), 32'hA5);
        tick();
        check("t1_ov_early", 32'(out_valid), 32'd0);
        tick();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'hA5);
        check("t1_level", 32'(level), 32'd1);
        drain("t1_drain");

        // 2: fill to DEPTH+1
        p0 = pushes;
        in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = 8'(i);
            tick();
        end
        check("t2_accepted", 32'(pushes - p0), 32'd257);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        check("t2_level", 32'(level), 32'd257);
        p0 = pushes;
        in_data = 8'hEE;
        repeat (3) tick();
        check("t2_refused", 32'(pushes - p0), 32'd0);
        check("t2_level_hold", 32'(level), 32'd257);

        // 3: pop from full, stream across pointer wrap
        out_ready = 1'b1;
        n = 257;
        in_data = 8'(n);
        check("t3_ready_full", 32'(in_ready), 32'd0);
        tick();
        check("t3_ready_after_pop", 32'(in_ready), 32'd1);
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(n);
            if (in_ready) n++;
            tick();
        end
        drain("t3_drain");

        // 4: 1000-word stream, one word per clock each way
        p0 = pushes;
        q0 = pops;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_data = 8'(i * 13 + 5);
            tick();
        end
        check("t4_accepted", 32'(pushes - p0), 32'd1000);
        check("t4_popped", 32'(pops - q0), 32'd997);
        check("t4_level_steady", 32'(level), 32'd3);
        drain("t4_drain");

        // 5: flush with 10 words stored
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(8'h80 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("t5_level_pre", 32'(level), 32'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        q0 = pops;
        for (int i = 0; i < 10 && pops == q0; i++) tick();
        check("t5_pop_count", 32'(pops - q0), 32'd1);
        check("t5_readback", 32'(last_pop), 32'h3C);
        drain("t5_drain");

        // 6: asynchronous reset mid-stream
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(8'h40 + i);
            tick();
        end
        check("t6_we_before", 32'(ram_we_0), 32'd1);
        check("t6_ov_before", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("t6_we_drop", 32'(ram_we_0), 32'd0);
        check("t6_ov_drop", 32'(out_valid), 32'd0);
        check("t6_level_rst", 32'(level), 32'd0);
        check("t6_in_ready_rst", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) tick();
        check("t6_level_after", 32'(level), 32'd0);
        check("t6_ov_after", 32'(out_valid), 32'd0);
        check("t6_cs1_after", 32'(ram_cs_1), 32'd0);
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        q0 = pops;
        for (int i = 0; i < 10 && pops == q0; i++) tick();
        check("t6_readback", 32'(last_pop), 32'h5A);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
